uart_rx: RTL and testbench



---
 rtl/uart_rx_if.sv | 10 +
 rtl/uart_rx.sv | 101 ++++++++++
 tb/tb_uart_rx.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, received byte with one-cycle strobe and activity LED out.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data_out;
  logic       ready;
  logic       led_rx;

  modport master (input rx, output data_out, output ready, output led_rx);
  modport slave  (output rx, input data_out, input ready, input led_rx);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with centre sampling; byte presented with a one-cycle ready strobe
// in the cycle after the stop-bit sample. No backpressure: an unconsumed byte is overwritten.
module uart_rx #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic      clk,
  input  logic      clr,
  uart_rx_if.master bus
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_sync;
  logic          armed;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_ff @(posedge clk) begin
    if (clr) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_sync <= rx_meta;
    end
  end

  // armed is dropped on a framing error so a line held low cannot retrigger a frame
  always_ff @(posedge clk) begin
    if (clr) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      armed        <= 1'b0;
      bus.data_out <= '0;
      bus.ready    <= 1'b0;
      bus.led_rx   <= 1'b0;
    end else begin
      bus.ready <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (rx_sync) begin
            armed <= 1'b1;
          end else if (armed) begin
            state      <= START;
            bus.led_rx <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            if (rx_sync) begin
              state      <= IDLE;
              bus.led_rx <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt            <= '0;
            shreg[bit_idx] <= rx_sync;
            if (bit_idx == 3'd7) state <= STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt        <= '0;
            state      <= IDLE;
            bus.led_rx <= 1'b0;
            if (rx_sync) begin
              bus.data_out <= shreg;
              bus.ready    <= 1'b1;
            end else begin
              armed <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with an expected-byte scoreboard checked on every ready strobe.
module tb_uart_rx;
  localparam int CPB  = 64;
  localparam int HALF = CPB / 2;

  logic clk = 1'b0;
  logic clr;
  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         rdy_cnt = 0;
  int         cyc = 0;
  int         last_rdy = 0;
  int         prev_rdy = 0;
  logic       rdy_prev = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every ready strobe must match the oldest expected byte.
  always @(negedge clk) begin
    cyc++;
    if (clr === 1'b0 && bus.ready === 1'b1) begin
      rdy_cnt++;
      prev_rdy = last_rdy;
      last_rdy = cyc;
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_ready observed=%02h expected=none", bus.data_out);
      end
      if (exp_q.size() != 0) begin
        exp_b = exp_q.pop_front();
        total++;
        assert (bus.data_out === exp_b) else begin
          bad++;
          $error("FAIL rx_byte observed=%02h expected=%02h", bus.data_out, exp_b);
        end
      end
      total++;
      assert (rdy_prev === 1'b0) else begin
        bad++;
        $error("FAIL ready_width observed=2+cycles expected=1");
      end
    end
    rdy_prev = bus.ready;
  end

  task automatic drive_bit(input logic b);
    bus.rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_b);
    bus.rx = 1'b0;
    repeat (HALF) @(negedge clk);
    check("led_in_frame", 32'(bus.led_rx), 32'd1);
    repeat (CPB - HALF) @(negedge clk);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_b);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr    = 1'b1;
    bus.rx = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_data_out", 32'(bus.data_out), 32'h00);
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_led", 32'(bus.led_rx), 32'd0);
    clr = 1'b0;

    // basic frame
    repeat (10 * CPB) @(negedge clk);
    exp_q.push_back(8'h0F);
    send_byte(8'h0F, 1'b1);
    repeat (4) @(negedge clk);
    check("basic_rdy_cnt", 32'(rdy_cnt), 32'd1);
    check("basic_data", 32'(bus.data_out), 32'h0F);
    check("basic_led_off", 32'(bus.led_rx), 32'd0);

    // back-to-back frames
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hA3);
    send_byte(8'h55, 1'b1);
    send_byte(8'hA3, 1'b1);
    repeat (4) @(negedge clk);
    check("b2b_rdy_cnt", 32'(rdy_cnt), 32'd3);
    check("b2b_gap", 32'(last_rdy - prev_rdy), 32'(10 * CPB));
    check("b2b_data", 32'(bus.data_out), 32'hA3);

    // short glitch rejected at start-bit centre
    repeat (CPB) @(negedge clk);
    bus.rx = 1'b0;
    repeat (4) @(negedge clk);
    bus.rx = 1'b1;
    check("glitch_led_hi", 32'(bus.led_rx), 32'd1);
    for (int i = 0; i < HALF && bus.led_rx === 1'b1; i++) @(negedge clk);
    check("glitch_led_lo", 32'(bus.led_rx), 32'd0);
    repeat (CPB) @(negedge clk);
    check("glitch_no_rdy", 32'(rdy_cnt), 32'd3);

    // framing error with line held low afterwards
    send_byte(8'h3C, 1'b0);
    repeat (CPB) @(negedge clk);
    check("ferr_not_rearmed", 32'(bus.led_rx), 32'd0);
    check("ferr_no_rdy", 32'(rdy_cnt), 32'd3);
    check("ferr_data_kept", 32'(bus.data_out), 32'hA3);
    bus.rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1);
    repeat (4) @(negedge clk);
    check("after_ferr_rdy_cnt", 32'(rdy_cnt), 32'd4);
    check("after_ferr_data", 32'(bus.data_out), 32'h81);

    // reset during data bit 4
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    repeat (HALF) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    check("midrst_data", 32'(bus.data_out), 32'h00);
    check("midrst_led", 32'(bus.led_rx), 32'd0);
    check("midrst_ready", 32'(bus.ready), 32'd0);
    repeat (2) @(negedge clk);
    clr = 1'b0;
    repeat (5 * CPB) @(negedge clk);
    check("midrst_no_rdy", 32'(rdy_cnt), 32'd4);
    exp_q.push_back(8'hFF);
    send_byte(8'hFF, 1'b1);
    repeat (4) @(negedge clk);
    check("post_rst_rdy_cnt", 32'(rdy_cnt), 32'd5);
    check("post_rst_data", 32'(bus.data_out), 32'hFF);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
